exe_lsu_pipe: RTL and testbench

- Registered, handshaked execute/memory stage that replaces the combinational execute path.
- ALU result or load data is produced into an output register held for writeback, with valid/ready on both sides.
- Memory accesses use a req/ack bus with a parametrised number of chip selects, per-byte enables and a timeout.
- Misaligned, unmapped and timed-out accesses are reported as exceptions instead of silently reading garbage.

---
 rtl/exe_lsu_pipe.sv | 258 +++++++++++++++++++++++++
 tb/tb_exe_lsu_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_lsu_pipe.sv
// Registered execute/memory stage: ALU result or bus load/store into a
// held writeback register, with valid/ready on both sides.
// Optional: EXE_STALL_CNT_EN enables the bus-wait cycle counter stall_cnt_o.
// Ports: clk_i, rst_ni (async, active-low); in_* issue handshake and
// operands; out_* / rd_* / reg_we_o / exc_o writeback; bus_* memory bus.

module alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    // 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra,
    // 8 or, 9 and, other: pass b
    always_comb begin
        y = b;
        case (op)
            4'd0: y = a + b;
            4'd1: y = a - b;
            4'd2: y = a << b[4:0];
            4'd3: y = {31'd0, $signed(a) < $signed(b)};
            4'd4: y = {31'd0, a < b};
            4'd5: y = a ^ b;
            4'd6: y = a >> b[4:0];
            4'd7: y = $unsigned($signed(a) >>> b[4:0]);
            4'd8: y = a | b;
            4'd9: y = a & b;
            default: y = b;
        endcase
    end
endmodule

module exe_lsu_pipe #(
    parameter int REG_AW  = 5,
    parameter int N_CS    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_AW-1:0] rd_ptr_i,
    input  logic [31:0]       rs1_i,
    input  logic [31:0]       rs2_i,
    input  logic [31:0]       imm_i,
    input  logic [3:0]        alu_opcode_i,
    input  logic              alu_src_i,
    input  logic              reg_we_i,
    input  logic              mem_we_i,
    input  logic              mem_re_i,
    input  logic [1:0]        mem_hb_i,
    input  logic              mem_ul_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       rd_o,
    output logic [REG_AW-1:0] rd_ptr_o,
    output logic              reg_we_o,
    output logic [1:0]        exc_o,
    output logic              bus_req_o,
    input  logic              bus_ack_i,
    output logic [31:0]       bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [3:0]        bus_be_o,
    output logic              bus_we_o,
    output logic [N_CS-1:0]   bus_cs_o,
    input  logic [31:0]       bus_rdata_i,
    output logic [31:0]       stall_cnt_o
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nxt;

    logic [31:0]       op2;
    logic [31:0]       alu_y;
    logic              is_mem;
    logic              misal;
    logic              unmap;
    logic              accept;
    logic              go_req;
    logic              timeout;
    logic              done;
    logic [31:0]       wait_cnt;

    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [N_CS-1:0]   cs_q;
    logic [1:0]        hb_q;
    logic              ul_q;
    logic              rwe_q;
    logic [REG_AW-1:0] ptr_q;

    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [N_CS-1:0]   cs_d;
    logic [31:0]       lane;
    logic [31:0]       ld_data;

    assign op2 = alu_src_i ? imm_i : rs2_i;

    alu u_alu (
        .op (alu_opcode_i),
        .a  (rs1_i),
        .b  (op2),
        .y  (alu_y)
    );

    assign is_mem = mem_re_i | mem_we_i;
    assign misal  = ((mem_hb_i == 2'b01) & alu_y[0])
                  | (mem_hb_i[1] & (|alu_y[1:0]));
    assign unmap  = {1'b0, alu_y[31:28]} >= 5'(N_CS);
    assign accept = in_valid_i & in_ready_o;
    assign go_req = accept & is_mem & ~misal & ~unmap;

    // Limit hits on the TIMEOUT-th ack-less REQ cycle; a same-cycle ack wins.
    assign timeout = (TIMEOUT != 0) && (state == REQ) && !bus_ack_i
                     && (wait_cnt == 32'(TIMEOUT - 1));
    assign done    = (state == REQ) & (bus_ack_i | timeout);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go_req) state_nxt = REQ;
            REQ:  if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus_req_o  = (state == REQ);
        in_ready_o = (state == IDLE) & (~out_valid_o | out_ready_i);
    end

    // Bus-side encodings of the accepted access
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = rs2_i;
        if (mem_hb_i == 2'b00) begin
            be_d    = 4'b0001 << alu_y[1:0];
            wdata_d = {4{rs2_i[7:0]}};
        end else if (mem_hb_i == 2'b01) begin
            be_d    = alu_y[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{rs2_i[15:0]}};
        end
    end

    always_comb begin
        cs_d = '0;
        for (int k = 0; k < N_CS; k++)
            cs_d[k] = (alu_y[31:28] == 4'(k));
    end

    // Load lane extraction and extension
    always_comb begin
        lane    = bus_rdata_i >> {addr_q[1:0], 3'b000};
        ld_data = lane;
        if (hb_q == 2'b00)
            ld_data = {{24{~ul_q & lane[7]}}, lane[7:0]};
        else if (hb_q == 2'b01)
            ld_data = {{16{~ul_q & lane[15]}}, lane[15:0]};
    end

    // Pending access registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            cs_q    <= '0;
            hb_q    <= '0;
            ul_q    <= 1'b0;
            rwe_q   <= 1'b0;
            ptr_q   <= '0;
        end else if (go_req) begin
            addr_q  <= alu_y;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= mem_we_i;
            cs_q    <= cs_d;
            hb_q    <= mem_hb_i;
            ul_q    <= mem_ul_i;
            rwe_q   <= reg_we_i;
            ptr_q   <= rd_ptr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  wait_cnt <= '0;
        else if (go_req | done)       wait_cnt <= '0;
        else if (bus_req_o & ~bus_ack_i) wait_cnt <= wait_cnt + 32'd1;
    end

    // Bus outputs are forced low outside an active request
    assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : '0;
    assign bus_wdata_o = bus_req_o ? wdata_q : '0;
    assign bus_be_o    = bus_req_o ? be_q : '0;
    assign bus_we_o    = bus_req_o & we_q;
    assign bus_cs_o    = bus_req_o ? cs_q : '0;

    // Writeback register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            rd_o        <= '0;
            rd_ptr_o    <= '0;
            reg_we_o    <= 1'b0;
            exc_o       <= 2'b00;
        end else if (accept & ~go_req) begin
            out_valid_o <= 1'b1;
            rd_ptr_o    <= rd_ptr_i;
            if (!is_mem) begin
                rd_o     <= alu_y;
                reg_we_o <= reg_we_i;
                exc_o    <= 2'b00;
            end else begin
                rd_o     <= '0;
                reg_we_o <= 1'b0;
                exc_o    <= misal ? 2'b01 : 2'b10;
            end
        end else if (done) begin
            out_valid_o <= 1'b1;
            rd_ptr_o    <= ptr_q;
            exc_o       <= bus_ack_i ? 2'b00 : 2'b11;
            if (bus_ack_i & ~we_q) begin
                rd_o     <= ld_data;
                reg_we_o <= rwe_q;
            end else begin
                rd_o     <= '0;
                reg_we_o <= 1'b0;
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     stall_q <= '0;
        else if (bus_req_o & ~bus_ack_i) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_exe_lsu_pipe.sv
// Directed bench for exe_lsu_pipe: ALU path, loads/stores, faults,
// timeout, output hold and reset during a bus access.

module tb_exe_lsu_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rd_ptr_in;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  opc;
    logic        alu_src, reg_we_in, mem_we, mem_re, mem_ul;
    logic [1:0]  mem_hb;
    logic        out_valid, out_ready;
    logic [31:0] rd;
    logic [4:0]  rd_ptr_out;
    logic        reg_we_out;
    logic [1:0]  exc;
    logic        bus_req, bus_ack, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, stall_cnt;
    logic [3:0]  bus_be;
    logic [2:0]  bus_cs;

    int checks = 0;
    int failures = 0;
    int req_cycles;
    logic got_out;
    logic [1:0] t_exc;
    logic t_we;

    always #5 clk = ~clk;

    exe_lsu_pipe dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rd_ptr_i(rd_ptr_in), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .alu_opcode_i(opc), .alu_src_i(alu_src),
        .reg_we_i(reg_we_in), .mem_we_i(mem_we), .mem_re_i(mem_re),
        .mem_hb_i(mem_hb), .mem_ul_i(mem_ul),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_o(rd), .rd_ptr_o(rd_ptr_out), .reg_we_o(reg_we_out),
        .exc_o(exc),
        .bus_req_o(bus_req), .bus_ack_i(bus_ack),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_be_o(bus_be), .bus_we_o(bus_we), .bus_cs_o(bus_cs),
        .bus_rdata_i(bus_rdata), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ALU op: opcode 0 is add
    task automatic set_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] p);
        in_valid = 1'b1; rs1 = a; rs2 = b; imm = '0; opc = 4'd0;
        alu_src = 1'b0; reg_we_in = 1'b1; mem_we = 1'b0; mem_re = 1'b0;
        mem_hb = 2'b10; mem_ul = 1'b0; rd_ptr_in = p;
    endtask

    // Memory op: address = base + off through the add path
    task automatic set_mem(input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] data, input logic we,
                           input logic [1:0] hb, input logic ul,
                           input logic [4:0] p);
        in_valid = 1'b1; rs1 = base; rs2 = data; imm = off; opc = 4'd0;
        alu_src = 1'b1; reg_we_in = 1'b1; mem_we = we; mem_re = ~we;
        mem_hb = hb; mem_ul = ul; rd_ptr_in = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_rd", rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bus_ack = 1'b0;
        bus_rdata = '0;
        set_alu(0, 0, 0);
        in_valid = 1'b0;
        do_reset();
        step();
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_stall", stall_cnt, 0);

        // ADD 5+7
        set_alu(32'd5, 32'd7, 5'd3);
        @(negedge clk);
        check("add_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("add_valid", out_valid, 1);
        check("add_rd", rd, 32'd12);
        check("add_ptr", rd_ptr_out, 3);
        check("add_we", reg_we_out, 1);
        check("add_exc", exc, 0);
        check("add_no_req", bus_req, 0);

        // Back-to-back issue
        set_alu(32'd100, 32'hFFFF_FFFF, 5'd1);
        step();
        set_alu(32'h8000_0000, 32'h8000_0000, 5'd2);
        @(negedge clk);
        check("b2b_rd0", rd, 32'd99);
        check("b2b_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_rd1", rd, 32'd0);
        check("b2b_ptr1", rd_ptr_out, 2);
        step();
        @(negedge clk);
        check("b2b_drain", out_valid, 0);

        // LB 0x10000003, two wait cycles, ack on the third
        do_reset();
        set_mem(32'h1000_0000, 32'd3, 0, 1'b0, 2'b00, 1'b0, 5'd5);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lb_req", bus_req, 1);
        check("lb_addr", bus_addr, 32'h1000_0000);
        check("lb_be", bus_be, 4'b1000);
        check("lb_cs", bus_cs, 3'b010);
        check("lb_we", bus_we, 0);
        check("lb_in_ready", in_ready, 0);
        step();
        step();
        bus_ack = 1'b1; bus_rdata = 32'h80FF_FFFF;
        step();
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("lb_req_drop", bus_req, 0);
        check("lb_valid", out_valid, 1);
        check("lb_rd", rd, 32'hFFFF_FF80);
        check("lb_exc", exc, 0);
        check("lb_rwe", reg_we_out, 1);
        check("lb_ptr", rd_ptr_out, 5);
        check("lb_addr_idle", bus_addr, 0);
`ifdef EXE_STALL_CNT_EN
        check("lb_stall", stall_cnt, 32'd2);
`else
        check("lb_stall", stall_cnt, 32'd0);
`endif

        // LHU 0x00000002, immediate ack
        set_mem(32'h0, 32'd2, 0, 1'b0, 2'b01, 1'b1, 5'd6);
        step();
        in_valid = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
        @(negedge clk);
        check("lhu_be", bus_be, 4'b1100);
        check("lhu_cs", bus_cs, 3'b001);
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        check("lhu_rd", rd, 32'h0000_8001);

        // SH 0x1234ABCD to 0x00000002
        set_mem(32'h0, 32'd2, 32'h1234_ABCD, 1'b1, 2'b01, 1'b0, 5'd7);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("sh_be", bus_be, 4'b1100);
        check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        check("sh_we", bus_we, 1);
        check("sh_addr", bus_addr, 0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        check("sh_valid", out_valid, 1);
        check("sh_rwe", reg_we_out, 0);
        check("sh_rd", rd, 0);
        check("sh_exc", exc, 0);

        // SB replication
        set_mem(32'h2000_0000, 32'd1, 32'h0000_005A, 1'b1, 2'b00, 1'b0, 5'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
        check("sb_be", bus_be, 4'b0010);
        check("sb_cs", bus_cs, 3'b100);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;

        // Misaligned LW
        set_mem(32'h0, 32'd6, 0, 1'b0, 2'b10, 1'b0, 5'd8);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("mis_req", bus_req, 0);
        check("mis_valid", out_valid, 1);
        check("mis_exc", exc, 2'b01);
        check("mis_rwe", reg_we_out, 0);

        // Unmapped LW
        set_mem(32'h5000_0000, 32'd0, 0, 1'b0, 2'b10, 1'b0, 5'd9);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("unm_req", bus_req, 0);
        check("unm_exc", exc, 2'b10);
        check("unm_rwe", reg_we_out, 0);

        // Ack outside REQ is ignored
        step();
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_valid", out_valid, 0);

        // Timeout on region 0
        set_mem(32'h0, 32'h10, 0, 1'b0, 2'b10, 1'b0, 5'd10);
        step();
        in_valid = 1'b0;
        req_cycles = 0; got_out = 1'b0; t_exc = 2'b00; t_we = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_req) req_cycles++;
            if (out_valid && !got_out) begin
                got_out = 1'b1; t_exc = exc; t_we = reg_we_out;
            end
        end
        check("to_req_cycles", req_cycles, 15);
        check("to_seen", got_out, 1);
        check("to_exc", t_exc, 2'b11);
        check("to_rwe", t_we, 0);

        // Output hold with out_ready low
        step();
        out_ready = 1'b0;
        set_alu(32'd10, 32'd20, 5'd11);
        step();
        set_alu(32'd100, 32'd1, 5'd12);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_ready", in_ready, 0);
            check("hold_rd", rd, 32'd30);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_rd", rd, 32'd101);
        check("rel_ptr", rd_ptr_out, 12);

        // Reset during REQ
        set_mem(32'h2000_0000, 32'd0, 0, 1'b0, 2'b10, 1'b0, 5'd13);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("rreq_req", bus_req, 1);
        check("rreq_cs", bus_cs, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("rreq_drop", bus_req, 0);
        check("rreq_cs_drop", bus_cs, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rreq_valid", out_valid, 0);
        check("rreq_ready", in_ready, 1);
        check("rreq_idle_req", bus_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
